// File: rtl/control_fsm_if.sv
// Control bundle between the multi-cycle datapath and its controller.
// The controller side (master) consumes instruction fields and flags and
// drives every datapath strobe; the datapath side (slave) is the mirror.
interface control_fsm_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;

  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        pc_write;
  logic        pc_src;
  logic        ir_write;
  logic        load_mdr;
  logic        load_ab;
  logic        load_aluout;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        trap;
  logic [3:0]  state;
  logic [31:0] retired;

  modport master (
    input  opcode, funct3, funct7_5, zero, mem_ready,
    output alu_src_a, alu_src_b, alu_op, pc_write, pc_src, ir_write,
           load_mdr, load_ab, load_aluout, mem_read, mem_write,
           reg_write, mem_to_reg, trap, state, retired
  );

  modport slave (
    output opcode, funct3, funct7_5, zero, mem_ready,
    input  alu_src_a, alu_src_b, alu_op, pc_write, pc_src, ir_write,
           load_mdr, load_ab, load_aluout, mem_read, mem_write,
           reg_write, mem_to_reg, trap, state, retired
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV-subset controller: fetch/decode/execute FSM driving the
// datapath strobes, a sticky illegal-instruction trap state and a 32-bit
// retired-instruction counter.
module control_fsm (
  input  logic          clk,
  input  logic          rst_n,
  control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_ADDR      = 4'd5,
    S_LOAD_MEM  = 4'd6,
    S_LOAD_WB   = 4'd7,
    S_STORE_MEM = 4'd8,
    S_BRANCH    = 4'd9,
    S_LUI       = 4'd10,
    S_ALU_WB    = 4'd11,
    S_TRAP      = 4'd15
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;
  logic [2:0]  exec_op;
  logic        exec_legal;

  // Map funct3/funct7_5 to the ALU operation for register and immediate arithmetic.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    exec_op    = ALU_ADD;
    exec_legal = 1'b1;
    case (bus.funct3)
      3'b000:  exec_op = (state_q == S_EXEC_R && bus.funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  exec_op = ALU_AND;
      3'b110:  exec_op = ALU_OR;
      3'b100:  exec_op = ALU_XOR;
      3'b001:  exec_op = ALU_SLL;
      3'b101:  exec_op = ALU_SRL;
      3'b010:  exec_op = ALU_SLT;
      default: exec_legal = 1'b0;  // 011 has no ALU meaning here
    endcase
  end

  // State and retired-counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the counter is a plain register, not a memory, so it takes the async reset like the state.
    if (!rst_n) begin
      state_q   <= S_RESET;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OP_R)                                  state_d = S_EXEC_R;
        else if (bus.opcode == OP_I)                             state_d = S_EXEC_I;
        else if (bus.opcode == OP_LOAD  && bus.funct3 == 3'b011) state_d = S_ADDR;
        else if (bus.opcode == OP_STORE && bus.funct3 == 3'b011) state_d = S_ADDR;
        else if (bus.opcode == OP_BRANCH && bus.funct3[2:1] == 2'b00) state_d = S_BRANCH;
        else if (bus.opcode == OP_LUI)                           state_d = S_LUI;
        else                                                     state_d = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I: state_d = exec_legal ? S_ALU_WB : S_TRAP;
      S_ADDR:      state_d = (bus.opcode == OP_LOAD) ? S_LOAD_MEM : S_STORE_MEM;
      S_LOAD_MEM:  if (bus.mem_ready) state_d = S_LOAD_WB;
      S_LOAD_WB:   state_d = S_FETCH;
      S_STORE_MEM: if (bus.mem_ready) state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_LUI:       state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;  // unused codes 12-14
    endcase
  end

  // Datapath strobes decoded from the current state and live inputs.
  always_comb begin
    bus.alu_src_a   = 2'b00;
    bus.alu_src_b   = 2'b00;
    bus.alu_op      = ALU_ADD;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 1'b0;
    bus.ir_write    = 1'b0;
    bus.load_mdr    = 1'b0;
    bus.load_ab     = 1'b0;
    bus.load_aluout = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.trap        = 1'b0;
    retire          = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.load_ab     = 1'b1;
        bus.load_aluout = 1'b1;
        bus.alu_src_b   = 2'b11;  // branch target PC + (imm << 1)
      end
      S_EXEC_R: begin
        bus.alu_src_a   = 2'b01;
        bus.alu_op      = exec_op;
        bus.load_aluout = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a   = 2'b01;
        bus.alu_src_b   = 2'b10;
        bus.alu_op      = (state_q == S_EXEC_I) ? exec_op : ALU_ADD;
        bus.load_aluout = 1'b1;
      end
      S_LOAD_MEM: begin
        bus.mem_read = 1'b1;
        bus.load_mdr = bus.mem_ready;
      end
      S_LOAD_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
      end
      S_STORE_MEM: begin
        bus.mem_write = 1'b1;
        retire        = bus.mem_ready;
      end
      S_BRANCH: begin
        bus.alu_src_a = 2'b01;
        bus.alu_op    = ALU_SUB;
        bus.pc_src    = 1'b1;
        // only beq (000) and bne (001) reach this state
        bus.pc_write  = bus.funct3[0] ? !bus.zero : bus.zero;
        retire        = 1'b1;
      end
      S_LUI: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b10;
        bus.load_aluout = 1'b1;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
      end
      S_TRAP:  bus.trap = 1'b1;
      default: ;
    endcase
  end

  // Retired counter advances once per completed instruction, wrapping naturally.
  always_comb begin
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-instruction expected traces are built
// from the instruction class and memory-latency pattern, then compared with
// the DUT every cycle; a few literal checks pin the model.
module tb_control_fsm;

  typedef struct packed {
    logic [3:0]  state;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [2:0]  op;
    logic        pc_write;
    logic        pc_src;
    logic        ir_write;
    logic        load_mdr;
    logic        load_ab;
    logic        load_aluout;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        trap;
    logic [31:0] retired;
  } outs_t;

  typedef enum {C_R, C_I, C_LD, C_SD, C_BR, C_LUI, C_ILL} cls_e;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_SD = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;

  logic clk;
  logic rst_n;
  control_fsm_if bus ();

  control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_err = 0;
  int          n_checks = 0;
  logic [31:0] model_ret = '0;
  bit          release_pending = 0;
  int          cnt_state6 = 0;
  int          cnt_mdr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  function automatic outs_t blank(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic outs_t observe();
    outs_t o;
    o = {bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_write, bus.pc_src,
         bus.ir_write, bus.load_mdr, bus.load_ab, bus.load_aluout, bus.mem_read,
         bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.trap, bus.retired};
    return o;
  endfunction

  function automatic cls_e classify(input logic [6:0] opc, input logic [2:0] f3);
    if (opc == OP_R) return C_R;
    if (opc == OP_I) return C_I;
    if (opc == OP_LD && f3 == 3'd3) return C_LD;
    if (opc == OP_SD && f3 == 3'd3) return C_SD;
    if (opc == OP_BR && f3 <= 3'd1) return C_BR;
    if (opc == OP_LUI) return C_LUI;
    return C_ILL;
  endfunction

  // ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SLT 7
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input bit is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'd1 : 3'd0;
      3'b111:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b001:  return 3'd5;
      3'b101:  return 3'd6;
      3'b010:  return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // One clock cycle: drive mem_ready, compare every output mid-cycle, then advance.
  task automatic step(input logic mr, input outs_t e, input bit retire);
    outs_t exp_o, obs;
    bus.mem_ready = mr;
    exp_o = e;
    exp_o.retired = model_ret;
    @(negedge clk);
    obs = observe();
    check("cycle", {10'b0, obs}, {10'b0, exp_o});
    if (bus.state == 4'd6) cnt_state6++;
    if (bus.load_mdr) cnt_mdr++;
    @(posedge clk);
    if (retire) model_ret = model_ret + 32'd1;
    #1;
    if (release_pending) begin
      release dut.retired_q;
      release_pending = 0;
    end
  endtask

  task automatic trap_cycles(input int n);
    outs_t o;
    o = blank(4'd15);
    o.trap = 1'b1;
    for (int i = 0; i < n; i++) step(logic'(i % 2), o, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_state", 64'(bus.state), 64'd0);
    check("rst_trap", 64'(bus.trap), 64'd0);
    check("rst_retired", 64'(bus.retired), 64'd0);
    check("rst_strobes", 64'({bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_write, bus.pc_src,
                              bus.ir_write, bus.load_mdr, bus.load_ab, bus.load_aluout,
                              bus.mem_read, bus.mem_write, bus.reg_write, bus.mem_to_reg}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_ret = '0;
    step(1'b1, blank(4'd0), 0);
  endtask

  // Build and play the expected trace of one instruction starting in FETCH.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw, input bit abort_mem);
    outs_t o;
    cls_e  c;
    bus.opcode = opc; bus.funct3 = f3; bus.funct7_5 = f7; bus.zero = z;
    c = classify(opc, f3);
    o = blank(4'd1); o.mem_read = 1'b1; o.b = 2'b01;
    for (int i = 0; i < fw; i++) step(1'b0, o, 0);
    o.ir_write = 1'b1; o.pc_write = 1'b1;
    step(1'b1, o, 0);
    o = blank(4'd2); o.load_ab = 1'b1; o.load_aluout = 1'b1; o.b = 2'b11;
    step(1'b1, o, 0);
    case (c)
      C_R, C_I: begin
        o = blank((c == C_R) ? 4'd3 : 4'd4);
        o.a = 2'b01; o.b = (c == C_R) ? 2'b00 : 2'b10;
        o.op = alu_of(f3, f7, c == C_R); o.load_aluout = 1'b1;
        step(1'b1, o, 0);
        if (f3 == 3'b011) trap_cycles(3);
        else begin
          o = blank(4'd11); o.reg_write = 1'b1;
          step(1'b1, o, 1);
        end
      end
      C_LD, C_SD: begin
        o = blank(4'd5); o.a = 2'b01; o.b = 2'b10; o.load_aluout = 1'b1;
        step(1'b1, o, 0);
        if (c == C_LD) begin
          o = blank(4'd6); o.mem_read = 1'b1;
          for (int i = 0; i < mw; i++) step(1'b0, o, 0);
          if (!abort_mem) begin
            o.load_mdr = 1'b1;
            step(1'b1, o, 0);
            o = blank(4'd7); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
            step(1'b1, o, 1);
          end
        end else begin
          o = blank(4'd8); o.mem_write = 1'b1;
          for (int i = 0; i < mw; i++) step(1'b0, o, 0);
          step(1'b1, o, 1);
        end
      end
      C_BR: begin
        o = blank(4'd9); o.a = 2'b01; o.op = 3'd1; o.pc_src = 1'b1;
        o.pc_write = (f3 == 3'b000) ? z : !z;
        step(1'b1, o, 1);
      end
      C_LUI: begin
        o = blank(4'd10); o.a = 2'b10; o.b = 2'b10; o.load_aluout = 1'b1;
        step(1'b1, o, 0);
        o = blank(4'd11); o.reg_write = 1'b1;
        step(1'b1, o, 1);
      end
      default: trap_cycles(10);
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c6, cm;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    apply_reset();

    // add: states 1,2,3,11,1 and one retirement
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 2, 0, 0);
    check("add_retired", 64'(bus.retired), 64'd1);
    check("add_back_in_fetch", 64'(bus.state), 64'd1);

    run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, 0);  // sub
    run_instr(OP_I, 3'b000, 1'b1, 1'b0, 1, 0, 0);  // addi ignores funct7_5
    run_instr(OP_I, 3'b100, 1'b0, 1'b0, 0, 0, 0);  // xori
    run_instr(OP_R, 3'b010, 1'b0, 1'b1, 0, 0, 0);  // slt
    run_instr(OP_I, 3'b101, 1'b0, 1'b0, 0, 0, 0);  // srli
    run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0, 0);  // and
    run_instr(OP_R, 3'b110, 1'b1, 1'b0, 0, 0, 0);  // or
    run_instr(OP_I, 3'b001, 1'b0, 1'b0, 0, 0, 0);  // slli

    // ld with three stall cycles in LOAD_MEM
    c6 = cnt_state6; cm = cnt_mdr;
    run_instr(OP_LD, 3'b011, 1'b0, 1'b0, 0, 3, 0);
    check("ld_state6_cycles", 64'(cnt_state6 - c6), 64'd4);
    check("ld_mdr_pulses", 64'(cnt_mdr - cm), 64'd1);

    run_instr(OP_SD, 3'b011, 1'b0, 1'b0, 0, 1, 0);
    run_instr(OP_BR, 3'b000, 1'b0, 1'b1, 0, 0, 0);  // beq taken
    run_instr(OP_BR, 3'b001, 1'b0, 1'b1, 0, 0, 0);  // bne not taken
    run_instr(OP_BR, 3'b001, 1'b0, 1'b0, 0, 0, 0);  // bne taken
    run_instr(OP_BR, 3'b000, 1'b0, 1'b0, 0, 0, 0);  // beq not taken
    run_instr(OP_LUI, 3'b101, 1'b0, 1'b0, 0, 0, 0);
    check("retired_after_mix", 64'(bus.retired), 64'd16);

    // unsupported load width traps
    run_instr(OP_LD, 3'b010, 1'b0, 1'b0, 0, 0, 0);
    apply_reset();

    // all-ones opcode traps, stays there, reset recovers to FETCH
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    check("trap_state", 64'(bus.state), 64'd15);
    check("trap_flag", 64'(bus.trap), 64'd1);
    apply_reset();
    check("fetch_after_reset", 64'(bus.state), 64'd1);

    // funct3 011 in EXEC_R traps after execute
    run_instr(OP_R, 3'b011, 1'b0, 1'b0, 0, 0, 0);
    apply_reset();

    // reset in the middle of a load stall
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    run_instr(OP_LD, 3'b011, 1'b0, 1'b0, 0, 2, 1);
    apply_reset();

    // counter wrap: preload all ones, retire one sd
    force dut.retired_q = 32'hFFFF_FFFF;
    model_ret = 32'hFFFF_FFFF;
    release_pending = 1;
    run_instr(OP_SD, 3'b011, 1'b0, 1'b0, 1, 2, 0);
    check("wrap_retired", 64'(bus.retired), 64'd0);
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 0);
    check("post_wrap_retired", 64'(bus.retired), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have RESET_N  in  1  asynchronous, active-low reset.
REQ-003 SHALL have OPCODE  in  7  instruction bits [6:0] from IR.
REQ-004 SHALL have FUNCT3  in  3  instruction bits [14:12].
REQ-005 SHALL have FUNCT7_5  in  1  instruction bit 30.
REQ-006 SHALL have ZERO  in  1  ALU zero flag.
REQ-007 SHALL have MEM_READY  in  1  memory completes the current read or write this cycle.
REQ-008 SHALL have ALU_SRC_A  out  2  ALU A select: 00 PC, 01 A register, 10 zero.
REQ-009 SHALL have ALU_SRC_B  out  2  ALU B mux select: 00 B register, 01 constant 4, 10 sign-extended immediate, 11 immediate<<1.
REQ-010 SHALL have ALU_OP  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT.
REQ-011 SHALL have PC_WRITE, PC_SRC  out  1 each  PC load; PC source: 0 ALU result, 1 ALUOUT.
REQ-012 SHALL have IR_WRITE, LOAD_MDR, LOAD_AB, LOAD_ALUOUT  out  1 each  register load enables.
REQ-013 SHALL have MEM_READ, MEM_WRITE, REG_WRITE, MEM_TO_REG  out  1 each  memory strobes; regfile write; write-back source (0 ALUOUT, 1 MDR).
REQ-014 SHALL have TRAP  out  1  illegal instruction seen, sticky.
REQ-015 SHALL have STATE  out  4  current state code.
REQ-016 SHALL have RETIRED  out  32  retired-instruction counter.

Function
REQ-017 SHALL encode states RESET=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ADDR=5, LOAD_MEM=6, LOAD_WB=7, STORE_MEM=8, BRANCH=9, LUI=10, ALU_WB=11, TRAP=15; 12-14 unused and SHALL go to TRAP.
REQ-018 SHALL drive every output not named for a state to 0 in that state. Unnamed selects SHALL be 00 and ALU_OP SHALL be ADD.
REQ-019 SHALL leave RESET for FETCH unconditionally after one cycle.
REQ-020 FETCH SHALL assert MEM_READ, ALU_SRC_A=00, ALU_SRC_B=01, ADD.
- IR_WRITE and PC_WRITE SHALL equal MEM_READY.
- SHALL stay in FETCH until MEM_READY=1, then go to DECODE.
REQ-021 DECODE SHALL assert LOAD_AB, LOAD_ALUOUT, ALU_SRC_A=00, ALU_SRC_B=11, ADD (branch target). Next state by OPCODE:
- 0110011 -> EXEC_R.
- 0010011 -> EXEC_I.
- 0000011 with FUNCT3=011 -> ADDR.
- 0100011 with FUNCT3=011 -> ADDR.
- 1100011 with FUNCT3 in {000,001} -> BRANCH.
- 0110111 -> LUI.
- anything else -> TRAP.
REQ-022 EXEC_R SHALL use ALU_SRC_A=01, ALU_SRC_B=00 and assert LOAD_ALUOUT, then go to ALU_WB. ALU_OP by FUNCT3:
- 000 -> ADD if FUNCT7_5=0, SUB if 1.
- 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL, 010 SLT.
- 011 -> TRAP instead of ALU_WB.
REQ-023 EXEC_I SHALL behave as EXEC_R except ALU_SRC_B=10, and FUNCT3=000 SHALL always give ADD.
REQ-024 ADDR SHALL use ALU_SRC_A=01, ALU_SRC_B=10, ADD, assert LOAD_ALUOUT, then go to LOAD_MEM (OPCODE 0000011) or STORE_MEM.
REQ-025 LOAD_MEM SHALL assert MEM_READ with LOAD_MDR=MEM_READY, and hold until MEM_READY, then go to LOAD_WB.
REQ-026 LOAD_WB SHALL assert REG_WRITE and MEM_TO_REG=1, then go to FETCH.
REQ-027 STORE_MEM SHALL assert MEM_WRITE and hold until MEM_READY, then go to FETCH.
REQ-028 BRANCH SHALL use ALU_SRC_A=01, ALU_SRC_B=00, SUB, PC_SRC=1, then go to FETCH.
- PC_WRITE=ZERO when FUNCT3=000.
- PC_WRITE=!ZERO when FUNCT3=001.
REQ-029 LUI SHALL use ALU_SRC_A=10, ALU_SRC_B=10, ADD, assert LOAD_ALUOUT, then go to ALU_WB.
REQ-030 ALU_WB SHALL assert REG_WRITE with MEM_TO_REG=0, then go to FETCH.
REQ-031 TRAP SHALL hold TRAP=1, keep all other strobes 0, and remain in TRAP until reset.
REQ-032 RETIRED SHALL increment by 1 on the cycle of LOAD_WB, ALU_WB, BRANCH, or STORE_MEM with MEM_READY=1. It SHALL wrap from FFFFFFFF to 0.
REQ-033 All outputs except TRAP SHALL be combinational from state and inputs. TRAP SHALL be state-decoded.

Reset
REQ-034 RESET_N=0 SHALL immediately force STATE=RESET, RETIRED=0 and all strobes 0 and TRAP=0, including mid-memory-access or while in TRAP. Operation resumes at FETCH one cycle after release.

Verification
REQ-035 add (OPCODE 0110011, FUNCT3 000, FUNCT7_5 0), MEM_READY=1 -> states 1,2,3,11,1; RETIRED +1; ALU_OP 000 in EXEC_R.
REQ-036 ld with MEM_READY low 3 cycles in LOAD_MEM -> STATE=6 held 4 cycles, LOAD_MDR pulses once, then LOAD_WB with MEM_TO_REG=1.
REQ-037 beq then bne, each with ZERO=1 -> PC_WRITE=1 for beq, PC_WRITE=0 for bne, PC_SRC=1 in both.
REQ-038 OPCODE 1111111 -> TRAP=1, STATE=15 held for 10 cycles; RESET_N pulse -> STATE=0, TRAP=0, then FETCH.
REQ-039 Preload RETIRED to FFFFFFFF via 2^32-1 retirements, or by forcing in the bench, then retire one sd -> RETIRED=00000000.
